exec_cc_retire: RTL and testbench

- Consumer side of the execute-stage 4:1 ALU result select.
- Accepts the selected 32-bit result, carry-out and lane code, and derives ZF/SF/OF/CF.
- Updates the architectural condition-code register and evaluates the Y86 condition function for jXX/cmovXX.
- Presents a registered valE/cnd beat to the memory stage through a valid/ready handshake.

---
 rtl/exec_pkg.sv | 29 ++
 rtl/exec_cc_retire_if.sv | 37 +++
 rtl/cc_cond_eval.sv | 32 +++
 rtl/exec_cc_retire.sv | 107 ++++++++++
 tb/tb_exec_cc_retire.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: ALU lane codes, Y86 condition codes and
// the architectural condition-code register layout.
package exec_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_sel_e;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
    logic cf;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0, cf: 1'b0};

endpackage

// File: rtl/exec_cc_retire_if.sv
// Execute-to-memory beat bus of exec_cc_retire; slave is the block, master the driver.
interface exec_cc_retire_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned CFW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     alu_sel;
  logic [DW-1:0]  alu_y;
  logic           alu_co;
  logic           alu_a_msb;
  logic           alu_b_msb;
  logic           set_cc;
  logic [CFW-1:0] cond_fun;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_valE;
  logic           out_cnd;
  logic           out_cond_err;
  logic           cc_zf;
  logic           cc_sf;
  logic           cc_of;
  logic           cc_cf;

  modport master (
    output in_valid, alu_sel, alu_y, alu_co, alu_a_msb, alu_b_msb, set_cc, cond_fun, flush,
    output out_ready,
    input  in_ready, out_valid, out_valE, out_cnd, out_cond_err, cc_zf, cc_sf, cc_of, cc_cf
  );

  modport slave (
    input  in_valid, alu_sel, alu_y, alu_co, alu_a_msb, alu_b_msb, set_cc, cond_fun, flush,
    input  out_ready,
    output in_ready, out_valid, out_valE, out_cnd, out_cond_err, cc_zf, cc_sf, cc_of, cc_cf
  );
endinterface

// File: rtl/cc_cond_eval.sv
// Combinational Y86 condition function over a CC snapshot; codes above C_G flag an error.
module cc_cond_eval
  import exec_pkg::*;
#(
  parameter int unsigned CFW = 4
) (
  input  cc_t            cc_i,
  input  logic [CFW-1:0] cond_fun_i,
  output logic           cnd_o,
  output logic           err_o
);
  logic lt;
  logic unused_cf;

  assign lt        = cc_i.sf ^ cc_i.of;
  assign unused_cf = cc_i.cf;

  always_comb begin
    cnd_o = 1'b0;
    err_o = 1'b0;
    case (cond_fun_i)
      CFW'(C_YES): cnd_o = 1'b1;
      CFW'(C_LE):  cnd_o = lt | cc_i.zf;
      CFW'(C_L):   cnd_o = lt;
      CFW'(C_E):   cnd_o = cc_i.zf;
      CFW'(C_NE):  cnd_o = ~cc_i.zf;
      CFW'(C_GE):  cnd_o = ~lt;
      CFW'(C_G):   cnd_o = ~lt & ~cc_i.zf;
      default:     err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/exec_cc_retire.sv
// Execute-stage retire: derives flags, owns the CC register and registers valE/cnd for memory.
// Optional EXEC_CC_FWD_EN: a set_cc beat evaluates its condition on its own fresh flags.
module exec_cc_retire
  import exec_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned CFW = 4
) (
  input logic            clk,
  input logic            rst_n,
  exec_cc_retire_if.slave bus
);
  typedef enum logic {StEmpty, StFull} state_e;

  state_e        state_q, state_d;
  cc_t           cc_q, cc_d, flags, eval_cc;
  logic [DW-1:0] vale_q, vale_d;
  logic          cnd_q, cnd_d, err_q, err_d;
  logic          cnd, err, in_ready, accept, load;
  alu_sel_e      sel;

  always_comb begin
    sel      = alu_sel_e'(bus.alu_sel);
    flags.zf = (bus.alu_y == '0);
    flags.sf = bus.alu_y[DW-1];
    flags.cf = 1'b0;
    flags.of = 1'b0;
    unique case (sel)
      ALU_ADD: begin
        flags.cf = bus.alu_co;
        flags.of = (bus.alu_a_msb == bus.alu_b_msb) & (flags.sf != bus.alu_a_msb);
      end
      ALU_SUB: begin
        flags.cf = bus.alu_co;
        flags.of = (bus.alu_a_msb != bus.alu_b_msb) & (flags.sf != bus.alu_a_msb);
      end
      ALU_AND, ALU_XOR: ;
    endcase
  end

  always_comb begin
    eval_cc = cc_q;
`ifdef EXEC_CC_FWD_EN
    if (bus.set_cc) eval_cc = flags;
`endif
  end

  cc_cond_eval #(.CFW(CFW)) u_cond (
    .cc_i       (eval_cc),
    .cond_fun_i (bus.cond_fun),
    .cnd_o      (cnd),
    .err_o      (err)
  );

  assign in_ready = (state_q == StEmpty) | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  // A flushed beat is still handshaken upstream but leaves no trace here.
  assign load     = accept & ~bus.flush;

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    vale_d  = vale_q;
    cnd_d   = cnd_q;
    err_d   = err_q;
    if (load) begin
      vale_d = bus.alu_y;
      cnd_d  = cnd;
      err_d  = err;
      if (bus.set_cc) cc_d = flags;
    end
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StFull;
        StFull:  if (bus.out_ready && !accept) state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      cc_q    <= CC_RESET;
      vale_q  <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      vale_q  <= vale_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q == StFull);
  assign bus.out_valE     = vale_q;
  assign bus.out_cnd      = cnd_q;
  assign bus.out_cond_err = err_q;
  assign bus.cc_zf        = cc_q.zf;
  assign bus.cc_sf        = cc_q.sf;
  assign bus.cc_of        = cc_q.of;
  assign bus.cc_cf        = cc_q.cf;
endmodule

// File: tb/tb_exec_cc_retire.sv
// Bench for exec_cc_retire: directed vector table, hand corner sequences, random vs queue model.
module tb_exec_cc_retire;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_cc_retire_if #(.DW(32), .CFW(4)) bus ();

  exec_cc_retire #(.DW(32), .CFW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: pending output beats as a queue, CC as {zf,sf,of,cf}.
  typedef struct {
    logic [31:0] vale;
    logic        cnd;
    logic        err;
  } beat_t;

  beat_t      q[$];
  logic [3:0] m_cc;

  function automatic logic [3:0] derive(logic [1:0] sel, logic [31:0] y, logic co,
                                        logic am, logic bm);
    logic zf, sf, of, cf;
    zf = (y == 32'd0);
    sf = y[31];
    cf = (sel == 2'b00 || sel == 2'b01) ? co : 1'b0;
    // Overflow: operands' effective signs agree but the result sign differs; sub negates B.
    if (sel == 2'b00)      of = (am == bm) && (sf != am);
    else if (sel == 2'b01) of = (am != bm) && (sf != am);
    else                   of = 1'b0;
    return {zf, sf, of, cf};
  endfunction

  function automatic void cond(logic [3:0] cc, logic [3:0] fun, output logic c, output logic e);
    logic lt, eq;
    logic [6:0] tbl;
    lt  = cc[2] ^ cc[1];
    eq  = cc[3];
    tbl = {!lt && !eq, !lt, !eq, eq, lt, lt || eq, 1'b1};
    if (fun > 4'd6) begin
      c = 1'b0;
      e = 1'b1;
    end else begin
      c = tbl[fun];
      e = 1'b0;
    end
  endfunction

  // Check current outputs at the falling edge, then advance the model over the rising edge.
  task automatic tick();
    logic rdy, acc, c, e;
    logic [3:0] nf, ecc;
    beat_t b;
    @(negedge clk);
    rdy = (q.size() == 0) || bus.out_ready;
    chk1("in_ready", bus.in_ready, rdy);
    chk1("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk32("out_valE", bus.out_valE, q[0].vale);
      chk1("out_cnd", bus.out_cnd, q[0].cnd);
      chk1("out_cond_err", bus.out_cond_err, q[0].err);
    end
    chk32("cc", 32'({bus.cc_zf, bus.cc_sf, bus.cc_of, bus.cc_cf}), 32'(m_cc));
    acc = bus.in_valid && rdy;
    nf  = derive(bus.alu_sel, bus.alu_y, bus.alu_co, bus.alu_a_msb, bus.alu_b_msb);
    ecc = m_cc;
`ifdef EXEC_CC_FWD_EN
    if (bus.set_cc) ecc = nf;
`endif
    cond(ecc, bus.cond_fun, c, e);
    if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
    if (bus.flush) begin
      q.delete();
    end else if (acc) begin
      b.vale = bus.alu_y;
      b.cnd  = c;
      b.err  = e;
      q.push_back(b);
      if (bus.set_cc) m_cc = nf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] sel, logic [31:0] y, logic co, logic am, logic bm,
                       logic sc, logic [3:0] fun);
    bus.in_valid  = v;
    bus.alu_sel   = sel;
    bus.alu_y     = y;
    bus.alu_co    = co;
    bus.alu_a_msb = am;
    bus.alu_b_msb = bm;
    bus.set_cc    = sc;
    bus.cond_fun  = fun;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] y;
    logic        co;
    logic        am;
    logic        bm;
    logic        sc;
    logic [3:0]  fun;
    logic        cnd;
    logic        cnd_fwd;
    logic        err;
    logic [3:0]  cc;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic exp_cnd;
    logic [3:0] held_cc;

    tv[0]  = '{2'b00, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 4'b1000};
    tv[1]  = '{2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 4'b0110};
    tv[2]  = '{2'b01, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 4'b1001};
    tv[3]  = '{2'b10, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 4'b0100};
    tv[4]  = '{2'b11, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 4'b0100};
    tv[5]  = '{2'b01, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 4'b0110};
    tv[6]  = '{2'b00, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 4'b0011};
    tv[7]  = '{2'b00, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0, 4'b0011};
    tv[8]  = '{2'b11, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 1'b1, 4'b0011};
    tv[9]  = '{2'b10, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 4'b1000};
    tv[10] = '{2'b00, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 4'b1001};
    tv[11] = '{2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 4'b0100};

    // Reset
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    m_cc = 4'b1000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    chk32("rst_valE", bus.out_valE, 32'd0);
    chk1("rst_cnd", bus.out_cnd, 1'b0);
    chk1("rst_err", bus.out_cond_err, 1'b0);
    tick();

    // Directed vector table, back-to-back beats with the sink always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tv[i].sel, tv[i].y, tv[i].co, tv[i].am, tv[i].bm, tv[i].sc, tv[i].fun);
      tick();
      #3;
`ifdef EXEC_CC_FWD_EN
      exp_cnd = tv[i].cnd_fwd;
`else
      exp_cnd = tv[i].cnd;
`endif
      chk1("vec_valid", bus.out_valid, 1'b1);
      chk32("vec_valE", bus.out_valE, tv[i].y);
      chk1("vec_cnd", bus.out_cnd, exp_cnd);
      chk1("vec_err", bus.out_cond_err, tv[i].err);
      chk32("vec_cc", 32'({bus.cc_zf, bus.cc_sf, bus.cc_of, bus.cc_cf}), 32'(tv[i].cc));
    end
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: beat A held for 3 cycles while beat B waits upstream
    drive(1'b1, 2'b00, 32'h0000_00A0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 2'b01, 32'h0000_00B0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    bus.out_ready = 1'b0;
    held_cc = m_cc;
    repeat (3) begin
      tick();
      #3;
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      chk32("bp_valE", bus.out_valE, 32'h0000_00A0);
      chk32("bp_cc", 32'({bus.cc_zf, bus.cc_sf, bus.cc_of, bus.cc_cf}), 32'(held_cc));
    end
    bus.out_ready = 1'b1;
    tick();
    #3;
    chk1("bp_b_valid", bus.out_valid, 1'b1);
    chk32("bp_b_valE", bus.out_valE, 32'h0000_00B0);
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Flush with a same-cycle accept: beat and its CC update are dropped
    held_cc = m_cc;
    drive(1'b1, 2'b00, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk1("flush_valid", bus.out_valid, 1'b0);
    chk32("flush_cc", 32'({bus.cc_zf, bus.cc_sf, bus.cc_of, bus.cc_cf}), 32'(held_cc));
    tick();

    // Flush while full and stalled
    drive(1'b1, 2'b11, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    bus.out_ready = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk1("flush_full_valid", bus.out_valid, 1'b0);
    tick();

    // Asynchronous reset while full with SF set
    drive(1'b1, 2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk1("pre_rst_sf", bus.cc_sf, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", bus.out_valid, 1'b0);
    chk32("mid_rst_cc", 32'({bus.cc_zf, bus.cc_sf, bus.cc_of, bus.cc_cf}), 32'(4'b1000));
    q.delete();
    m_cc = 4'b1000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 4) > 1);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.alu_sel   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       bus.alu_y = 32'd0;
        1:       bus.alu_y = 32'h8000_0000;
        default: bus.alu_y = $urandom;
      endcase
      bus.alu_co    = 1'($urandom_range(0, 1));
      bus.alu_a_msb = 1'($urandom_range(0, 1));
      bus.alu_b_msb = 1'($urandom_range(0, 1));
      bus.set_cc    = 1'($urandom_range(0, 1));
      bus.cond_fun  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 6));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
